// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// The datapath is the master: it drives stage status and consumes the enables.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             if_id_valid;
  logic [31:0]      if_id_instr;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic             ex_mem_branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             id_ex_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       fsm_state;

  modport master (
    output if_id_valid, if_id_instr, id_ex_mem_read, id_ex_rt,
           ex_mem_branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold,
           stall_count, flush_count, fsm_state
  );

  modport slave (
    input  if_id_valid, if_id_instr, id_ex_mem_read, id_ex_rt,
           ex_mem_branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold,
           stall_count, flush_count, fsm_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencer: load-use stalls, taken-branch flushes and memory freeze,
// with saturating stall/flush statistics. fsm_state mirrors the state register.
module hazard_ctrl #(
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] LU_REM = (LU_CYCLES > 1) ? 2'(LU_CYCLES - 2) : 2'd0;
  localparam logic [1:0] FL_REM = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic [5:0]       op;
  logic [4:0]       rs, rt;
  logic             uses_rt, lu;

  assign op = bus.if_id_instr[31:26];
  assign rs = bus.if_id_instr[25:21];
  assign rt = bus.if_id_instr[20:16];
  // R-type, beq, bne and sw read rt as a source; other opcodes treat it as a destination.
  assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign lu = bus.if_id_valid && bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
              ((bus.id_ex_rt == rs) || (uses_rt && (bus.id_ex_rt == rt)));

  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.id_ex_hold   = 1'b0;
    if (!rst) begin
      bus.id_ex_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      bus.id_ex_hold = 1'b1;
    end else if (bus.ex_mem_branch_taken) begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      flush_inc        = 1'b1;
      state_d          = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      rem_d            = FL_REM;
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            bus.id_ex_bubble = 1'b1;
            stall_inc        = 1'b1;
            state_d          = (LU_CYCLES > 1) ? LU_STALL : RUN;
            rem_d            = LU_REM;
          end else begin
            bus.pc_write    = 1'b1;
            bus.if_id_write = 1'b1;
          end
        end
        LU_STALL: begin
          bus.id_ex_bubble = 1'b1;
          stall_inc        = 1'b1;
          if (rem_q == 2'd0) state_d = RUN;
          else rem_d = rem_q - 2'd1;
        end
        FLUSH: begin
          bus.pc_write     = 1'b1;
          bus.if_id_write  = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b1;
          if (rem_q == 2'd0) state_d = RUN;
          else rem_d = rem_q - 2'd1;
        end
        default: begin
          state_d = RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
  assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations share one stimulus stream and are
// each checked every cycle against a cycle-count model, plus literal spot checks.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid, mr, br, busy;
  logic [31:0] instr;
  logic [4:0]  ex_rt;

  hazard_ctrl_if #(.CNT_W(16)) b0 ();
  hazard_ctrl_if #(.CNT_W(16)) b1 ();
  hazard_ctrl_if #(.CNT_W(4))  b2 ();

  hazard_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  hazard_ctrl #(.LU_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
  hazard_ctrl #(.LU_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.if_id_valid = valid;  assign b1.if_id_valid = valid;  assign b2.if_id_valid = valid;
  assign b0.if_id_instr = instr;  assign b1.if_id_instr = instr;  assign b2.if_id_instr = instr;
  assign b0.id_ex_mem_read = mr;  assign b1.id_ex_mem_read = mr;  assign b2.id_ex_mem_read = mr;
  assign b0.id_ex_rt = ex_rt;     assign b1.id_ex_rt = ex_rt;     assign b2.id_ex_rt = ex_rt;
  assign b0.ex_mem_branch_taken = br;
  assign b1.ex_mem_branch_taken = br;
  assign b2.ex_mem_branch_taken = br;
  assign b0.mem_busy = busy;      assign b1.mem_busy = busy;      assign b2.mem_busy = busy;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold}
  logic [4:0] o[3];
  logic [1:0] st[3];
  int         sc[3], fc[3];
  always_comb begin
    o[0] = {b0.pc_write, b0.if_id_write, b0.if_id_flush, b0.id_ex_bubble, b0.id_ex_hold};
    o[1] = {b1.pc_write, b1.if_id_write, b1.if_id_flush, b1.id_ex_bubble, b1.id_ex_hold};
    o[2] = {b2.pc_write, b2.if_id_write, b2.if_id_flush, b2.id_ex_bubble, b2.id_ex_hold};
    st[0] = b0.fsm_state;  st[1] = b1.fsm_state;  st[2] = b2.fsm_state;
    sc[0] = int'(b0.stall_count);  sc[1] = int'(b1.stall_count);  sc[2] = int'(b2.stall_count);
    fc[0] = int'(b0.flush_count);  fc[1] = int'(b1.flush_count);  fc[2] = int'(b2.flush_count);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per configuration, how many stall / flush cycles are still owed after this one.
  int lu_n[3]  = '{1, 2, 3};
  int fl_n[3]  = '{1, 1, 3};
  int cw[3]    = '{16, 16, 4};
  int m_st[3]  = '{0, 0, 0};
  int m_fl[3]  = '{0, 0, 0};
  int m_sc[3]  = '{0, 0, 0};
  int m_fc[3]  = '{0, 0, 0};

  function automatic bit is_lu(logic v, logic [31:0] ins, logic m, logic [4:0] r);
    logic [5:0] opc;
    bit         uses;
    opc  = ins[31:26];
    uses = (opc == 6'h00) || (opc == 6'h04) || (opc == 6'h05) || (opc == 6'h2B);
    return v && m && (r != 5'd0) && ((r == ins[25:21]) || (uses && (r == ins[20:16])));
  endfunction

  function automatic int sat_inc(int x, int w);
    return (x >= (1 << w) - 1) ? x : x + 1;
  endfunction

  always @(negedge clk) begin : compare
    bit         l;
    logic [4:0] e;
    l = is_lu(valid, instr, mr, ex_rt);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_st[i] = 0;  m_fl[i] = 0;  m_sc[i] = 0;  m_fc[i] = 0;
      end
      chk($sformatf("cfg%0d stall_count", i), sc[i], m_sc[i]);
      chk($sformatf("cfg%0d flush_count", i), fc[i], m_fc[i]);
      if (!rst) e = 5'b00010;
      else if (busy) e = 5'b00001;
      else if (br) begin
        e = 5'b11110;
        m_fc[i] = sat_inc(m_fc[i], cw[i]);
        m_fl[i] = fl_n[i] - 1;
        m_st[i] = 0;
      end else if (m_fl[i] > 0) begin
        e = 5'b11110;
        m_fl[i]--;
      end else if (m_st[i] > 0) begin
        e = 5'b00010;
        m_sc[i] = sat_inc(m_sc[i], cw[i]);
        m_st[i]--;
      end else if (l) begin
        e = 5'b00010;
        m_sc[i] = sat_inc(m_sc[i], cw[i]);
        m_st[i] = lu_n[i] - 1;
      end else e = 5'b11000;
      chk($sformatf("cfg%0d outputs", i), int'(o[i]), int'(e));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    valid = 1'b0;  instr = 32'd0;  mr = 1'b0;  ex_rt = 5'd0;  br = 1'b0;  busy = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    idle();
    cyc();
    rst = 1'b1;
  endtask

  task automatic drive_lu();
    valid = 1'b1;
    instr = {6'h00, 5'd2, 5'd4, 5'd3, 11'h020};  // add $3,$2,$4
    mr    = 1'b1;
    ex_rt = 5'd2;
  endtask

  logic [5:0] ops[6] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};

  initial begin
    idle();
    look();
    chk("reset pc_write", int'(b0.pc_write), 0);
    chk("reset bubble", int'(b0.id_ex_bubble), 1);
    chk("reset hold", int'(b0.id_ex_hold), 0);
    cyc();
    rst = 1'b1;

    // Load-use with single-cycle stall
    drive_lu();
    look();
    chk("lu pc_write", int'(b0.pc_write), 0);
    chk("lu if_id_write", int'(b0.if_id_write), 0);
    chk("lu bubble", int'(b0.id_ex_bubble), 1);
    cyc();
    idle();
    look();
    chk("lu stall_count", sc[0], 1);
    chk("lu resumes", int'(b0.pc_write), 1);

    // No hazard: load writes $0, or addi whose rt is a destination
    valid = 1'b1;  mr = 1'b1;  ex_rt = 5'd0;
    instr = {6'h00, 5'd0, 5'd4, 5'd3, 11'h020};
    look();
    chk("rt zero no stall", int'(b0.pc_write), 1);
    cyc();
    ex_rt = 5'd2;
    instr = {6'h08, 5'd5, 5'd2, 16'd1};
    look();
    chk("addi no stall", int'(b0.pc_write), 1);
    cyc();
    idle();

    // Branch taken during a 2-cycle load-use stall
    do_reset();
    drive_lu();
    look();
    cyc();
    idle();
    br = 1'b1;
    look();
    chk("br in stall flush", int'(b1.if_id_flush), 1);
    cyc();
    br = 1'b0;
    look();
    chk("br in stall state", int'(st[1]), 0);
    chk("br in stall stall_count", sc[1], 1);
    chk("br in stall flush_count", fc[1], 1);

    // Three-cycle flush
    do_reset();
    br = 1'b1;
    for (int k = 0; k < 3; k++) begin
      look();
      chk($sformatf("flush3 flush c%0d", k), int'(b2.if_id_flush), 1);
      chk($sformatf("flush3 pc_write c%0d", k), int'(b2.pc_write), 1);
      cyc();
      br = 1'b0;
    end
    look();
    chk("flush3 done", int'(b2.if_id_flush), 0);
    chk("flush3 flush_count", fc[2], 1);

    // Memory freeze in the middle of a flush
    do_reset();
    br = 1'b1;
    look();
    cyc();
    br = 1'b0;
    busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk($sformatf("busy hold c%0d", k), int'(b2.id_ex_hold), 1);
      chk($sformatf("busy pc_write c%0d", k), int'(b2.pc_write), 0);
      cyc();
    end
    busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      look();
      chk($sformatf("resume flush c%0d", k), int'(b2.if_id_flush), 1);
      cyc();
    end
    look();
    chk("resume done", int'(b2.if_id_flush), 0);
    chk("busy flush_count", fc[2], 1);

    // Asynchronous reset in the middle of a 3-cycle stall
    do_reset();
    drive_lu();
    look();
    cyc();
    idle();
    look();
    chk("mid stall state", int'(st[2]), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async reset outputs", int'(o[2]), 2);
    chk("async reset state", int'(st[2]), 0);
    chk("async reset stall_count", sc[2], 0);
    look();
    cyc();
    rst = 1'b1;
    look();
    chk("post reset state", int'(st[2]), 0);
    chk("post reset stall_count", sc[2], 0);

    // Saturation of the 4-bit counters
    do_reset();
    drive_lu();
    repeat (20) cyc();
    look();
    chk("sat cfg2 stall_count", sc[2], 15);
    chk("nosat cfg0 stall_count", sc[0], 20);
    cyc();
    look();
    chk("sat hold stall_count", sc[2], 15);

    // Random traffic
    do_reset();
    repeat (3000) begin
      cyc();
      rst   = ($urandom_range(0, 299) != 0);
      valid = ($urandom_range(0, 3) != 0);
      instr = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 16'($urandom)};
      mr    = 1'($urandom_range(0, 1));
      ex_rt = 5'($urandom_range(0, 3));
      br    = ($urandom_range(0, 7) == 0);
      busy  = ($urandom_range(0, 7) == 0);
    end
    cyc();
    rst = 1'b1;
    idle();
    look();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
